// File: rtl/digit_shift_pkg.sv
// Shared FSM state encoding and sizing helpers for the multi-digit display shifter.
// No logic, no latency; no flow control.
package digit_shift_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    localparam int DEFAULT_SEG_BITS = 8;

    // Counter width for a range of n values, never below one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_tick_gen.sv
// Phase counter: o_tick is high on the last of every CLK_DIV cycles, counting from a clear.
// Latency: tick CLK_DIV-1 cycles after i_clear drops; no flow control.
module shift_tick_gen
    import digit_shift_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int W = cnt_width(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] r_div_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
        end else if (i_clear || o_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    assign o_tick = (r_div_cnt == LAST);

endmodule

// File: rtl/multi_digit_shifter.sv
// Serialises a NUM_DIGITS x SEG_BITS frame onto a shift-register display with own shift clock/latch.
// Latency: start edge to done = TOTAL*2*CLK_DIV + CLK_DIV + 1 cycles; start ignored while busy.
// Optional SHIFT_AUTO_REFRESH_EN: re-sends the last frame after REFRESH_CYCLES idle cycles.
module multi_digit_shifter
    import digit_shift_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int SEG_BITS       = DEFAULT_SEG_BITS,
    parameter int CLK_DIV        = 2,
    parameter int MSB_FIRST      = 0,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           start,
    input  logic [NUM_DIGITS*SEG_BITS-1:0] digits_in,
    output logic                           busy,
    output logic                           done,
    output logic                           serial_out,
    output logic                           shift_clk,
    output logic                           latch
);

    localparam int TOTAL = NUM_DIGITS * SEG_BITS;
    localparam int BW    = cnt_width(TOTAL);
    localparam int FIRST = (MSB_FIRST != 0) ? TOTAL - 1 : 0;
    localparam logic [BW-1:0] BIT_LAST = BW'(TOTAL - 1);

    if (NUM_DIGITS < 1 || SEG_BITS < 1 || CLK_DIV < 1 || REFRESH_CYCLES < 1) begin : g_param_check
        $error("multi_digit_shifter: all size parameters must be >= 1");
    end

    state_t            r_state;
    logic [TOTAL-1:0]  r_frame;
    logic [BW-1:0]     r_bit_cnt;
    logic              r_busy;
    logic              r_done;
    logic              r_serial;
    logic              r_sclk;
    logic              r_latch;
    logic              w_tick;
    logic              w_clear;
    logic              w_refresh;

    // r_bit_cnt counts bits still to go; map it onto the frame position being sent.
    function automatic logic [BW-1:0] bit_index(input logic [BW-1:0] remaining);
        return (MSB_FIRST != 0) ? remaining : (BIT_LAST - remaining);
    endfunction

    assign w_clear = (r_state == IDLE);

    shift_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (w_clear),
        .o_tick  (w_tick)
    );

`ifdef SHIFT_AUTO_REFRESH_EN
    localparam int IW = cnt_width(REFRESH_CYCLES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(REFRESH_CYCLES - 1);

    logic [IW-1:0] r_idle_cnt;

    // An external start in the trigger cycle wins and captures fresh digits.
    assign w_refresh = (r_state == IDLE) && !start && (r_idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idle_cnt <= '0;
        end else if (r_state != IDLE || start || w_refresh) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    assign w_refresh = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_frame   <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_serial  <= 1'b0;
            r_sclk    <= 1'b0;
            r_latch   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start || w_refresh) begin
                        if (start) begin
                            r_frame  <= digits_in;
                            r_serial <= digits_in[FIRST];
                        end else begin
                            r_serial <= r_frame[FIRST];
                        end
                        r_bit_cnt <= BIT_LAST;
                        r_busy    <= 1'b1;
                        r_sclk    <= 1'b0;
                        r_latch   <= 1'b0;
                        r_state   <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (w_tick) begin
                        r_sclk  <= 1'b1;
                        r_state <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (w_tick) begin
                        r_sclk <= 1'b0;
                        if (r_bit_cnt == '0) begin
                            r_latch  <= 1'b1;
                            r_serial <= 1'b0;
                            r_state  <= LATCH;
                        end else begin
                            r_bit_cnt <= r_bit_cnt - 1'b1;
                            r_serial  <= r_frame[bit_index(r_bit_cnt - 1'b1)];
                            r_state   <= SHIFT_LO;
                        end
                    end
                end
                LATCH: begin
                    if (w_tick) begin
                        r_latch <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign serial_out = r_serial;
    assign shift_clk  = r_sclk;
    assign latch      = r_latch;

endmodule

// File: tb/tb_multi_digit_shifter.sv
// Bench for multi_digit_shifter: LSB-first and MSB-first instances driven in parallel,
// checked every cycle against a timeline model plus literal per-test expectations.
module tb_multi_digit_shifter;

    localparam int ND  = 2;
    localparam int SB  = 8;
    localparam int CD  = 2;
    localparam int TOT = ND * SB;
    localparam int SH  = TOT * 2 * CD;
    localparam int L   = SH + CD;
    localparam int RC  = 50;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [TOT-1:0] digits_in = '0;

    logic busy_l, done_l, ser_l, sclk_l, latch_l;
    logic busy_m, done_m, ser_m, sclk_m, latch_m;

    always #5 clk = ~clk;

    multi_digit_shifter #(
        .NUM_DIGITS(ND), .SEG_BITS(SB), .CLK_DIV(CD), .MSB_FIRST(0), .REFRESH_CYCLES(RC)
    ) u_dut_l (
        .clk(clk), .reset_n(reset_n), .start(start), .digits_in(digits_in),
        .busy(busy_l), .done(done_l), .serial_out(ser_l), .shift_clk(sclk_l), .latch(latch_l)
    );

    multi_digit_shifter #(
        .NUM_DIGITS(ND), .SEG_BITS(SB), .CLK_DIV(CD), .MSB_FIRST(1), .REFRESH_CYCLES(RC)
    ) u_dut_m (
        .clk(clk), .reset_n(reset_n), .start(start), .digits_in(digits_in),
        .busy(busy_m), .done(done_m), .serial_out(ser_m), .shift_clk(sclk_m), .latch(latch_m)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: position m_t cycles into a transfer decides every output.
    bit             m_act = 1'b0;
    bit             m_done = 1'b0;
    int             m_t = 0;
    int             m_idle = 0;
    logic [TOT-1:0] m_frame = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_act = 1'b0; m_done = 1'b0; m_t = 0; m_idle = 0; m_frame = '0;
        end else if (m_act) begin
            m_t++;
            if (m_t == L) begin
                m_act  = 1'b0;
                m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            m_idle++;
            if (start) begin
                m_frame = digits_in; m_act = 1'b1; m_t = 0; m_idle = 0;
            end
`ifdef SHIFT_AUTO_REFRESH_EN
            else if (m_idle == RC) begin
                m_act = 1'b1; m_t = 0; m_idle = 0;
            end
`endif
        end
    end

    function automatic logic [4:0] expv(input bit msb);
        logic ser, sc, la;
        int k;
        ser = 1'b0; sc = 1'b0;
        if (m_act && m_t < SH) begin
            k   = m_t / (2 * CD);
            sc  = (m_t % (2 * CD)) >= CD;
            ser = m_frame[msb ? TOT - 1 - k : k];
        end
        la = m_act && (m_t >= SH);
        return {m_act, m_done, ser, sc, la};
    endfunction

    always @(negedge clk) begin
        check("cycle_lsb", {busy_l, done_l, ser_l, sclk_l, latch_l}, expv(1'b0));
        check("cycle_msb", {busy_m, done_m, ser_m, sclk_m, latch_m}, expv(1'b1));
    end

    // Monitor: bits as seen by the display on each shift_clk rise, latch timing.
    bit q_l[$];
    bit q_m[$];
    logic prev_sclk_l = 1'b0, prev_sclk_m = 1'b0, prev_latch_m = 1'b0;
    int latch_cyc = 0;
    int latch_at = 0;

    always @(negedge clk) begin
        if (sclk_l && !prev_sclk_l) q_l.push_back(ser_l);
        if (sclk_m && !prev_sclk_m) q_m.push_back(ser_m);
        if (latch_m && !prev_latch_m) latch_at = q_m.size();
        if (latch_m) latch_cyc++;
        prev_sclk_l  = sclk_l;
        prev_sclk_m  = sclk_m;
        prev_latch_m = latch_m;
    end

    task automatic get_frame(input int base, input bit msb, output logic [TOT-1:0] f);
        f = '0;
        for (int i = 0; i < TOT; i++) begin
            if (msb) begin
                if (base + i < q_m.size()) f[TOT-1-i] = q_m[base + i];
            end else begin
                if (base + i < q_l.size()) f[i] = q_l[base + i];
            end
        end
    endtask

    // Called #1 after a posedge; start is seen at the next edge.
    task automatic pulse_and_wait(input logic [TOT-1:0] d, input bit change_mid,
                                  output int edges, output bit ok);
        digits_in = d;
        start = 1'b1;
        edges = 0;
        ok = 1'b0;
        while (edges < 200 && !ok) begin
            @(posedge clk); #1;
            edges++;
            start = 1'b0;
            if (change_mid && edges == 20) digits_in = 16'hFFFF;
            if (done_l) ok = 1'b1;
        end
    endtask

    task automatic frame_test(input string name, input logic [TOT-1:0] d, input bit change_mid);
        int bl, bm, lc, e;
        bit ok;
        logic [TOT-1:0] fl, fm;
        bl = q_l.size(); bm = q_m.size(); lc = latch_cyc;
        pulse_and_wait(d, change_mid, e, ok);
        check({name, "_done_seen"}, ok, 1);
        check({name, "_latency"}, e, 67);
        check({name, "_rises"}, q_l.size() - bl, 16);
        get_frame(bl, 1'b0, fl);
        get_frame(bm, 1'b1, fm);
        check({name, "_lsb_first_bits"}, fl, d);
        check({name, "_msb_first_bits"}, fm, d);
        check({name, "_latch_cycles"}, latch_cyc - lc, 2);
        check({name, "_latch_after_rise"}, latch_at - bm, 16);
    endtask

    initial begin
        int e, nd, d1, d2, r1, bl, lc;
        bit ok;
        logic [TOT-1:0] f;

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {busy_l, done_l, ser_l, sclk_l, latch_l,
                              busy_m, done_m, ser_m, sclk_m, latch_m}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Test 1/2: basic frame, both bit orders; literal bit sequence pins the model.
        frame_test("t1", 16'hA53C, 1'b0);
        bl = q_l.size() - 16;
        f = '0;
        for (int i = 0; i < 16; i++) f[15-i] = q_l[bl + i];
        check("t1_seq_as_shifted", f, 16'b0011110010100101);
        frame_test("t2", 16'h8001, 1'b0);

        // Test 4: digits_in changes mid-transfer.
        frame_test("t4", 16'hA53C, 1'b1);

        // Test 3: start held high across transfers.
        digits_in = 16'h5A0F;
        start = 1'b1;
        e = 0; nd = 0; d1 = 0; d2 = 0; r1 = 0;
        while (e < 400 && nd < 2) begin
            @(posedge clk); #1;
            e++;
            if (done_l) begin
                nd++;
                if (nd == 1) begin
                    d1 = e; r1 = q_l.size();
                end else begin
                    d2 = e; start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("t3_two_dones", nd, 2);
        check("t3_done_to_done", d2 - d1, 67);
        check("t3_rises_in_window", q_l.size() - r1, 16);
        get_frame(r1, 1'b0, f);
        check("t3_frame", f, 16'h5A0F);

        // Test 5: asynchronous reset mid-frame.
        bl = q_l.size();
        digits_in = 16'hC3A5;
        start = 1'b1;
        e = 0;
        while (e < 200 && (q_l.size() - bl) < 7) begin
            @(posedge clk); #1;
            e++;
            start = 1'b0;
        end
        check("t5_reached_bit7", q_l.size() - bl, 7);
        #2 reset_n = 1'b0;
        #1;
        check("t5_async_zero", {busy_l, done_l, ser_l, sclk_l, latch_l,
                                busy_m, done_m, ser_m, sclk_m, latch_m}, 0);
        nd = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done_l || done_m) nd++;
        end
        check("t5_no_done_in_reset", nd, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        frame_test("t5_after", 16'hA53C, 1'b0);

        // Idle period: auto re-send only when the refresh feature is built in.
        bl = q_l.size();
        lc = 0;
        e = 0;
        ok = 1'b0;
        while (e < 150 && !ok) begin
            @(posedge clk); #1;
            e++;
            if (done_l) ok = 1'b1;
        end
`ifdef SHIFT_AUTO_REFRESH_EN
        check("rf_done_seen", ok, 1);
        check("rf_interval", e, RC + L);
        get_frame(bl, 1'b0, f);
        check("rf_frame", f, 16'hA53C);
`else
        check("idle_no_done", ok, 0);
        check("idle_no_shift", q_l.size() - bl, lc);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
